// File: rtl/i2c_apb_sequencer.sv
// ============================================================================
// i2c_apb_sequencer: arbitrates two requesters and sequences I2C master
// register accesses over an APB master port.  Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_apb_sequencer #(
  parameter logic [7:0]  PRESCALE   = 8'd4,
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_rw_i,
  input  logic [13:0] req_addr_i,
  input  logic [7:0]  req_len_i,
  input  logic [15:0] wr_data_i,
  output logic [1:0]  wr_pop_o,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  typedef enum logic [3:0] {
    IDLE, ARB, CFG_PRE, CFG_ADDR, LOAD_TX, CMD_EN, POLL, READ_RX, CMD_DIS, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [7:0]  pwdata_q, pwdata_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        apb_done;
  logic        acc_en;
  logic        acc_write;
  logic [7:0]  acc_addr;
  logic [7:0]  acc_data;
  logic        sel;
  logic [3:0]  sel_len;
  logic [7:0]  tx_byte;
  logic        poll_exit;
  logic [1:0]  wr_pop;
  logic        unused_prdata;

  assign unused_prdata = ^prdata_i[31:8];
  assign apb_done  = psel_q & penable_q & pready_i;
  assign tx_byte   = gnt_q[1] ? wr_data_i[15:8] : wr_data_i[7:0];
  assign poll_exit = rw_q ? prdata_i[5] : (prdata_i[7] & prdata_i[5]);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    last_d     = last_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_pop     = 2'b00;
    acc_en     = 1'b0;
    acc_write  = 1'b1;
    acc_addr   = 8'h00;
    acc_data   = 8'h00;
    sel        = 1'b0;
    sel_len    = 4'd0;

    case (state_q)
      IDLE: begin
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (req_i == 2'b00) begin
          state_d = IDLE;
        end else begin
          // Both requesting: the one not served last wins.
          sel     = (req_i == 2'b11) ? ~last_q : req_i[1];
          sel_len = sel ? req_len_i[7:4] : req_len_i[3:0];
          gnt_d   = sel ? 2'b10 : 2'b01;
          rw_d    = req_rw_i[sel];
          addr_d  = sel ? req_addr_i[13:7] : req_addr_i[6:0];
          len_d   = sel_len;
          cnt_d   = 4'd0;
          err_d   = (sel_len == 4'd0);
          state_d = (sel_len == 4'd0) ? DONE : CFG_PRE;
        end
      end
      CFG_PRE: begin
        acc_en   = 1'b1;
        acc_addr = 8'h00;
        acc_data = PRESCALE;
        if (apb_done) state_d = CFG_ADDR;
      end
      CFG_ADDR: begin
        acc_en   = 1'b1;
        acc_addr = 8'h04;
        acc_data = {addr_q, rw_q};
        if (apb_done) state_d = rw_q ? CMD_EN : LOAD_TX;
      end
      LOAD_TX: begin
        acc_en   = 1'b1;
        acc_addr = 8'h02;
        acc_data = tx_byte;
        if (apb_done) begin
          wr_pop = gnt_q;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == len_q) state_d = CMD_EN;
        end
      end
      CMD_EN: begin
        acc_en     = 1'b1;
        acc_addr   = 8'h01;
        acc_data   = 8'h60;
        poll_cnt_d = 16'd0;
        if (apb_done) state_d = POLL;
      end
      POLL: begin
        acc_en    = 1'b1;
        acc_write = 1'b0;
        acc_addr  = 8'h03;
        if (apb_done) begin
          if (poll_exit) begin
            cnt_d   = 4'd0;
            state_d = rw_q ? READ_RX : CMD_DIS;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (poll_cnt_q + 16'd1 == POLL_LIMIT) begin
              err_d   = 1'b1;
              state_d = CMD_DIS;
            end
          end
        end
      end
      READ_RX: begin
        acc_en    = 1'b1;
        acc_write = 1'b0;
        acc_addr  = 8'h05;
        if (apb_done) begin
          rd_valid_d = 1'b1;
          rd_data_d  = prdata_i[7:0];
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == len_q) state_d = CMD_DIS;
        end
      end
      CMD_DIS: begin
        acc_en   = 1'b1;
        acc_addr = 8'h01;
        acc_data = 8'h20;
        if (apb_done) state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared APB engine; a completed access always leaves one idle cycle
    // before the next SETUP.
    if (acc_en) begin
      if (!psel_q) begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = acc_write;
        paddr_d   = acc_addr;
        pwdata_d  = acc_write ? acc_data : 8'h00;
      end else if (!penable_q) begin
        penable_d = 1'b1;
      end else if (pready_i) begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      len_q      <= 4'd0;
      cnt_q      <= 4'd0;
      poll_cnt_q <= 16'd0;
      err_q      <= 1'b0;
      last_q     <= 1'b1;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 8'h00;
      pwdata_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      last_q     <= last_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wr_pop_o   = wr_pop;
  assign gnt_o      = gnt_q;
  assign done_o     = (state_q == DONE) ? gnt_q : 2'b00;
  assign err_o      = (state_q == DONE) & err_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q != IDLE);
  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign pwrite_o   = pwrite_q;
  assign paddr_o    = {24'h0, paddr_q};
  assign pwdata_o   = {24'h0, pwdata_q};

endmodule

`default_nettype wire

// File: tb/tb_i2c_apb_sequencer.sv
// ============================================================================
// tb_i2c_apb_sequencer: directed and randomized transactions checked against
// a transaction-level model of the register sequence.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_apb_sequencer;
  localparam int         PL = 4;
  localparam logic [7:0] PS = 8'h04;

  logic        pclk_i = 1'b0;
  logic        preset_i = 1'b1;
  logic [1:0]  req_i = 2'b00;
  logic [1:0]  req_rw_i;
  logic [13:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic [15:0] wr_data_i;
  logic [1:0]  wr_pop_o, gnt_o, done_o;
  logic        err_o, rd_valid_o, busy_o, psel_o, penable_o, pwrite_o;
  logic [7:0]  rd_data_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [31:0] prdata_i = 32'h0;
  logic        pready_i = 1'b0;

  i2c_apb_sequencer #(.PRESCALE(PS), .POLL_LIMIT(16'(PL))) dut (
    .pclk_i(pclk_i), .preset_i(preset_i), .req_i(req_i), .req_rw_i(req_rw_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .wr_data_i(wr_data_i),
    .wr_pop_o(wr_pop_o), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  // Requester configuration and slave response scripts
  logic       cfg_rw [2];
  logic [6:0] cfg_addr [2];
  logic [3:0] cfg_len [2];
  logic [7:0] cfg_bytes [2][16];
  logic [7:0] stat_arr [16];
  int         stat_n = 1;
  logic [7:0] rx_arr [16];
  int         pop_cnt [2] = '{0, 0};
  int         pop_base [2] = '{0, 0};
  int         poll_idx = 0, poll_base = 0, rx_idx = 0, rx_base = 0;
  bit         hold_flag = 0, rand_wait = 0;
  int         wait_cnt = 0;
  logic [3:0] idx0, idx1;

  assign req_rw_i   = {cfg_rw[1], cfg_rw[0]};
  assign req_addr_i = {cfg_addr[1], cfg_addr[0]};
  assign req_len_i  = {cfg_len[1], cfg_len[0]};
  assign idx0       = 4'(pop_cnt[0] - pop_base[0]);
  assign idx1       = 4'(pop_cnt[1] - pop_base[1]);
  assign wr_data_i  = {cfg_bytes[1][idx1], cfg_bytes[0][idx0]};

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // APB slave: responds shortly after each rising edge
  always @(posedge pclk_i) begin
    int si;
    logic [31:0] rnd;
    #1;
    rnd = $urandom;
    if (psel_o && !penable_o) wait_cnt = rand_wait ? int'($urandom_range(0, 2)) : 0;
    if (psel_o && penable_o && !hold_flag && wait_cnt == 0) begin
      pready_i = 1'b1;
      if (paddr_o == 32'h3) begin
        si = poll_idx - poll_base;
        if (si >= stat_n) si = stat_n - 1;
        prdata_i = {rnd[31:8], stat_arr[si]};
        poll_idx++;
      end else if (paddr_o == 32'h5) begin
        si = rx_idx - rx_base;
        prdata_i = {rnd[31:8], rx_arr[si[3:0]]};
        rx_idx++;
      end else begin
        prdata_i = rnd;
      end
    end else begin
      pready_i = 1'b0;
      if (psel_o && penable_o && !hold_flag && wait_cnt > 0) wait_cnt--;
    end
  end

  // Monitor: logs completed accesses, pulses and protocol violations
  logic [16:0] log_q [$];
  logic [7:0]  rd_q [$];
  int          done_cnt = 0, psel_cnt = 0, proto_viol = 0, cyc = 0;
  int          gnt_cyc = 0, done_cyc = 0;
  logic [1:0]  done_val = 2'b00, prev_gnt = 2'b00;
  logic        err_val = 1'b0;
  logic        prev_psel = 0, prev_pen = 0, prev_done = 0, prev_wr = 0, prev_rxdone = 0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;

  always @(negedge pclk_i) begin
    logic cur_done;
    cyc++;
    cur_done = psel_o & penable_o & pready_i;
    if (penable_o && !psel_o) proto_viol++;
    if (penable_o && !prev_pen && !prev_psel) proto_viol++;
    if (psel_o && !penable_o && prev_psel && !prev_pen) proto_viol++;
    if (penable_o && prev_pen && !prev_done &&
        (paddr_o != prev_addr || pwdata_o != prev_wdata || pwrite_o != prev_wr)) proto_viol++;
    if (prev_done && psel_o) proto_viol++;
    if (psel_o && paddr_o[31:8] != 24'h0) proto_viol++;
    if (psel_o) psel_cnt++;
    if (cur_done)
      log_q.push_back({pwrite_o, paddr_o[7:0], pwrite_o ? pwdata_o[7:0] : prdata_i[7:0]});
    if (wr_pop_o != 2'b00 && !(cur_done && pwrite_o && paddr_o == 32'h2)) proto_viol++;
    for (int j = 0; j < 2; j++) if (wr_pop_o[j]) pop_cnt[j]++;
    if (rd_valid_o !== prev_rxdone) proto_viol++;
    if (rd_valid_o) rd_q.push_back(rd_data_o);
    if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_cyc = cyc;
    if (done_o != 2'b00) begin
      done_cnt++;
      done_val = done_o;
      err_val  = err_o;
      done_cyc = cyc;
    end
    if (err_o && done_o == 2'b00) proto_viol++;
    prev_rxdone = cur_done && !pwrite_o && paddr_o == 32'h5;
    prev_psel = psel_o; prev_pen = penable_o; prev_done = cur_done;
    prev_wr = pwrite_o; prev_addr = paddr_o; prev_wdata = pwdata_o;
    prev_gnt = gnt_o;
  end

  int m_last = 1;

  task automatic do_txn(input logic [1:0] reqs, input string tag, output int k);
    logic [16:0] exp_q [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  s;
    logic [1:0]  oh;
    logic        exp_err, ok;
    int          lb, rb, db, psb, vb, t, si, len;
    k   = (reqs == 2'b11) ? (m_last == 0 ? 1 : 0) : (reqs[1] ? 1 : 0);
    oh  = (k == 1) ? 2'b10 : 2'b01;
    len = int'(cfg_len[k]);
    exp_err = 1'b1;
    if (len != 0) begin
      exp_q.push_back({1'b1, 8'h00, PS});
      exp_q.push_back({1'b1, 8'h04, cfg_addr[k], cfg_rw[k]});
      if (!cfg_rw[k]) for (int i = 0; i < len; i++) exp_q.push_back({1'b1, 8'h02, cfg_bytes[k][i]});
      exp_q.push_back({1'b1, 8'h01, 8'h60});
      ok = 1'b0;
      for (int p = 0; p < PL && !ok; p++) begin
        si = (p < stat_n) ? p : stat_n - 1;
        s  = stat_arr[si];
        exp_q.push_back({1'b0, 8'h03, s});
        ok = cfg_rw[k] ? s[5] : (s[7] & s[5]);
      end
      exp_err = !ok;
      if (ok && cfg_rw[k]) for (int i = 0; i < len; i++) begin
        exp_q.push_back({1'b0, 8'h05, rx_arr[i]});
        exp_rd.push_back(rx_arr[i]);
      end
      exp_q.push_back({1'b1, 8'h01, 8'h20});
    end
    lb = log_q.size(); rb = rd_q.size(); db = done_cnt; psb = psel_cnt; vb = proto_viol;
    pop_base[0] = pop_cnt[0]; pop_base[1] = pop_cnt[1];
    poll_base = poll_idx; rx_base = rx_idx;
    req_i = reqs;
    for (t = 0; t < 20 && gnt_o == 2'b00; t++) @(negedge pclk_i);
    chk({tag, "_grant"}, 32'(gnt_o), 32'(oh));
    if (reqs != 2'b11) req_i = 2'b00;
    for (t = 0; t < 600 && done_cnt == db; t++) @(negedge pclk_i);
    @(negedge pclk_i);
    chk({tag, "_done_count"}, 32'(done_cnt - db), 32'd1);
    chk({tag, "_done"}, 32'(done_val), 32'(oh));
    chk({tag, "_err"}, 32'(err_val), 32'(exp_err));
    chk({tag, "_n_access"}, 32'(log_q.size() - lb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_access"}, (lb + i < log_q.size()) ? 32'(log_q[lb + i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    chk({tag, "_n_rd"}, 32'(rd_q.size() - rb), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      chk({tag, "_rd_data"}, (rb + i < rd_q.size()) ? 32'(rd_q[rb + i]) : 32'hFFFF_FFFF, 32'(exp_rd[i]));
    chk({tag, "_pops"}, 32'(pop_cnt[k] - pop_base[k]), (cfg_rw[k] || len == 0) ? 32'd0 : 32'(len));
    chk({tag, "_pops_other"}, 32'(pop_cnt[1 - k] - pop_base[1 - k]), 32'd0);
    chk({tag, "_protocol"}, 32'(proto_viol - vb), 32'd0);
    if (len == 0) begin
      chk({tag, "_len0_psel"}, 32'(psel_cnt - psb), 32'd0);
      chk({tag, "_len0_latency"}, 32'(done_cyc - gnt_cyc <= 2), 32'd1);
    end
    m_last = k;
  endtask

  task automatic set_req(input int k, input logic rw, input logic [6:0] a, input logic [3:0] l);
    cfg_rw[k] = rw; cfg_addr[k] = a; cfg_len[k] = l;
    for (int i = 0; i < 16; i++) cfg_bytes[k][i] = 8'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_psel"}, 32'(psel_o), 32'd0);
    chk({tag, "_penable"}, 32'(penable_o), 32'd0);
    chk({tag, "_pwrite"}, 32'(pwrite_o), 32'd0);
    chk({tag, "_paddr"}, paddr_o, 32'd0);
    chk({tag, "_pwdata"}, pwdata_o, 32'd0);
    chk({tag, "_gnt_done_err"}, {27'd0, gnt_o, done_o, err_o}, 32'd0);
    chk({tag, "_busy_pop"}, {29'd0, busy_o, wr_pop_o}, 32'd0);
    chk({tag, "_rd"}, {23'd0, rd_valid_o, rd_data_o}, 32'd0);
  endtask

  initial begin
    int k, db, t;
    logic [31:0] a0, d0;
    for (int j = 0; j < 2; j++) set_req(j, 1'b0, 7'h00, 4'd1);
    for (int i = 0; i < 16; i++) begin stat_arr[i] = 8'hA0; rx_arr[i] = 8'($urandom); end
    repeat (3) @(negedge pclk_i);
    check_idle_outputs("reset");
    preset_i = 1'b0;
    @(negedge pclk_i);

    // Back-to-back contention right after reset: order 0,1,0
    set_req(0, 1'b0, 7'h12, 4'd1);
    set_req(1, 1'b1, 7'h34, 4'd1);
    stat_n = 1; stat_arr[0] = 8'hA0;
    do_txn(2'b11, "rr1", k); chk("rr_order1", 32'(k), 32'd0);
    do_txn(2'b11, "rr2", k); chk("rr_order2", 32'(k), 32'd1);
    do_txn(2'b11, "rr3", k); chk("rr_order3", 32'(k), 32'd0);
    req_i = 2'b00;
    repeat (4) @(negedge pclk_i);

    // Requester 0 write of two bytes
    set_req(0, 1'b0, 7'h50, 4'd2);
    cfg_bytes[0][0] = 8'hA1; cfg_bytes[0][1] = 8'hA2;
    stat_n = 1; stat_arr[0] = 8'hA0;
    do_txn(2'b01, "wr2", k);

    // Requester 1 read of three bytes
    set_req(1, 1'b1, 7'h3C, 4'd3);
    stat_arr[0] = 8'h20;
    rx_arr[0] = 8'h11; rx_arr[1] = 8'h22; rx_arr[2] = 8'h33;
    do_txn(2'b10, "rd3", k);

    // Status never ready: poll timeout
    set_req(0, 1'b0, 7'h21, 4'd1);
    stat_arr[0] = 8'h00;
    do_txn(2'b01, "timeout", k);

    // Zero-length request
    set_req(1, 1'b0, 7'h55, 4'd0);
    do_txn(2'b10, "len0", k);

    // Randomized traffic with random wait states
    rand_wait = 1;
    for (int n = 0; n < 24; n++) begin
      logic [1:0] rq;
      for (int j = 0; j < 2; j++)
        set_req(j, 1'($urandom), 7'($urandom),
                ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 4)));
      stat_n = int'($urandom_range(1, 6));
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 4))
          0: stat_arr[i] = 8'h00;
          1: stat_arr[i] = 8'hA0;
          2: stat_arr[i] = 8'h80;
          3: stat_arr[i] = 8'h20;
          default: stat_arr[i] = 8'($urandom);
        endcase
        rx_arr[i] = 8'($urandom);
      end
      rq = 2'($urandom_range(1, 3));
      do_txn(rq, "rand", k);
    end
    rand_wait = 0;
    req_i = 2'b00;
    repeat (4) @(negedge pclk_i);

    // Stalled ACCESS phase, then reset in the middle of it
    set_req(0, 1'b0, 7'h44, 4'd1);
    hold_flag = 1;
    req_i = 2'b01;
    for (t = 0; t < 30 && !penable_o; t++) @(negedge pclk_i);
    chk("hold_reached", 32'(penable_o), 32'd1);
    a0 = paddr_o; d0 = pwdata_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk_i);
      chk("hold_penable", 32'(penable_o), 32'd1);
      chk("hold_paddr", paddr_o, a0);
      chk("hold_pwdata", pwdata_o, d0);
    end
    db = done_cnt;
    preset_i = 1'b1;
    req_i = 2'b00;
    @(negedge pclk_i);
    check_idle_outputs("midreset");
    preset_i = 1'b0;
    hold_flag = 0;
    repeat (10) @(negedge pclk_i);
    chk("midreset_no_done", 32'(done_cnt - db), 32'd0);

    // Round-robin pointer must be back at requester 0 priority
    m_last = 1;
    set_req(0, 1'b1, 7'h0A, 4'd1);
    set_req(1, 1'b0, 7'h0B, 4'd1);
    stat_n = 1; stat_arr[0] = 8'hA0;
    do_txn(2'b11, "rr_after_reset", k);
    chk("rr_after_reset_order", 32'(k), 32'd0);
    req_i = 2'b00;
    repeat (4) @(negedge pclk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
